// File: rtl/repeater_fork_pipe.sv
// repeater_fork_pipe
//   An elastic repeater pipeline feeding a multi-load fork. A word accepted
//   from the driver passes through DEPTH skid-buffer stages. The last stage
//   is the fork head, and every load takes the head word independently. The
//   head retires only when all loads have taken it.
//
// Parameters
//   WIDTH      data bits per transfer
//   DEPTH      number of skid-buffer stages (capacity 2*DEPTH words)
//   NUM_LOADS  number of fanout load channels
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    driver offers s_data
//   s_ready    block accepts (straight from a register)
//   s_data     driver data
//   m_valid    per-load valid
//   m_ready    per-load ready
//   m_data     per-load data, load i at [i*WIDTH +: WIDTH]
//   in_flight  accepted words not yet taken by every load
module repeater_fork_pipe #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int NUM_LOADS = 3,
  localparam int CntW     = $clog2(2*DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic [NUM_LOADS-1:0]       m_valid,
  input  logic [NUM_LOADS-1:0]       m_ready,
  output logic [NUM_LOADS*WIDTH-1:0] m_data,
  output logic [CntW-1:0]            in_flight
);

  // Handshake links between stages. Link 0 is the driver side, link DEPTH
  // is the fork head.
  logic             linkValid [DEPTH+1];
  logic [WIDTH-1:0] linkData  [DEPTH+1];
  logic             linkReady [DEPTH+1];

  logic                 retire;
  logic                 sFire;
  logic [NUM_LOADS-1:0] done_q, done_d;
  logic [CntW-1:0]      inFlight_q, inFlight_d;

  assign linkValid[0] = s_valid;
  assign linkData[0]  = s_data;
  assign s_ready      = linkReady[0];
  assign sFire        = s_valid && s_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : gStage
    logic             mainValid_q, mainValid_d;
    logic             skidValid_q, skidValid_d;
    logic [WIDTH-1:0] mainData_q, mainData_d;
    logic [WIDTH-1:0] skidData_q, skidData_d;

    // Ready is the inverse of the skid flag, so it is a register output and
    // never sees the downstream ready combinationally.
    assign linkReady[g]   = !skidValid_q;
    assign linkValid[g+1] = mainValid_q;
    assign linkData[g+1]  = mainData_q;

    // The main register is the stage output. An incoming word lands in main
    // when main is empty or moving on this edge; otherwise it parks in skid.
    // A parked word moves to main as soon as downstream takes the old one.
    always_comb begin
      mainValid_d = mainValid_q;
      skidValid_d = skidValid_q;
      mainData_d  = mainData_q;
      skidData_d  = skidData_q;
      if (skidValid_q) begin
        if (linkReady[g+1]) begin
          mainData_d  = skidData_q;
          skidValid_d = 1'b0;
        end
      end else if (linkValid[g]) begin
        if (!mainValid_q || linkReady[g+1]) begin
          mainValid_d = 1'b1;
          mainData_d  = linkData[g];
        end else begin
          skidValid_d = 1'b1;
          skidData_d  = linkData[g];
        end
      end else if (linkReady[g+1]) begin
        mainValid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mainValid_q <= 1'b0;
        skidValid_q <= 1'b0;
      end else begin
        mainValid_q <= mainValid_d;
        skidValid_q <= skidValid_d;
      end
    end

    // Data registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
    end
  end

  // Fork: a load is offered the head until it has taken it. The head retires
  // once every load is either already done or taking it on this edge, which
  // keeps fast loads from running ahead of slow ones.
  always_comb begin
    retire  = linkValid[DEPTH] && (&(done_q | m_ready));
    m_valid = {NUM_LOADS{linkValid[DEPTH]}} & ~done_q;
    m_data  = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      m_data[i*WIDTH +: WIDTH] = linkData[DEPTH];
    end
    if (retire) begin
      done_d = '0;
    end else begin
      done_d = done_q | (m_valid & m_ready);
    end
  end

  assign linkReady[DEPTH] = retire;

  // Occupancy counter: up on accept, down on retire, unchanged on both.
  always_comb begin
    inFlight_d = inFlight_q;
    case ({sFire, retire})
      2'b10:   inFlight_d = inFlight_q + CntW'(1);
      2'b01:   inFlight_d = inFlight_q - CntW'(1);
      default: inFlight_d = inFlight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= '0;
      inFlight_q <= '0;
    end else begin
      done_q     <= done_d;
      inFlight_q <= inFlight_d;
    end
  end

  assign in_flight = inFlight_q;

endmodule

// File: tb/tb_repeater_fork_pipe.sv
// Testbench for repeater_fork_pipe. Directed scenarios run on a default
// instance (WIDTH=8, DEPTH=2, NUM_LOADS=3); two corner instances
// (DEPTH=1/NUM_LOADS=1 and DEPTH=8/NUM_LOADS=8) take random traffic. Every
// instance is watched by a count-based model: the words accepted so far and
// how many of them each load has taken.
module tb_repeater_fork_pipe;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  // Model state per instance (0 = main, 1..2 = corners).
  int         accCnt  [3];
  int         rxCnt   [3][8];
  logic       held    [3][8];
  logic [7:0] sentMem [3][2048];

  // Main instance signals.
  logic        sValid;
  logic        sReady;
  logic [7:0]  sData;
  logic [2:0]  mValid;
  logic [2:0]  mReady;
  logic [23:0] mData;
  logic [2:0]  inFlight;

  repeater_fork_pipe #(.WIDTH(8), .DEPTH(2), .NUM_LOADS(3)) uDut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (sValid),
    .s_ready   (sReady),
    .s_data    (sData),
    .m_valid   (mValid),
    .m_ready   (mReady),
    .m_data    (mData),
    .in_flight (inFlight)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int minRx(input int id, input int nl);
    int m;
    m = rxCnt[id][0];
    for (int i = 1; i < nl; i++) begin
      if (rxCnt[id][i] < m) m = rxCnt[id][i];
    end
    return m;
  endfunction

  // Called between edges with stable inputs: checks occupancy and every
  // offered word against the model, then books the transfers that the
  // coming edge will perform.
  task automatic observe(input int id, input int nl, input logic sV, input logic sR,
                         input logic [7:0] sD, input logic [7:0] mV, input logic [7:0] mR,
                         input logic [63:0] mD, input logic [7:0] inF);
    int lo;
    int idx;
    if (!rst_n) begin
      accCnt[id] = 0;
      for (int i = 0; i < 8; i++) begin
        rxCnt[id][i] = 0;
        held[id][i]  = 1'b0;
      end
      return;
    end
    lo = minRx(id, nl);
    checkOutput($sformatf("inflight%0d", id), 64'(inF), 64'(accCnt[id] - lo));
    for (int i = 0; i < nl; i++) begin
      if (held[id][i]) checkOutput($sformatf("hold%0d_%0d", id, i), 64'(mV[i]), 64'd1);
      if (mV[i]) begin
        idx = rxCnt[id][i];
        checkOutput($sformatf("ahead%0d_%0d", id, i), 64'(idx > lo), 64'd0);
        checkOutput($sformatf("phantom%0d_%0d", id, i), 64'(idx < accCnt[id]), 64'd1);
        if (idx < accCnt[id]) begin
          checkOutput($sformatf("data%0d_%0d", id, i), 64'(mD[i*8 +: 8]), 64'(sentMem[id][idx % 2048]));
        end
        if (mR[i]) rxCnt[id][i]++;
      end
      held[id][i] = mV[i] && !mR[i];
    end
    if (sV && sR) begin
      sentMem[id][accCnt[id] % 2048] = sD;
      accCnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    observe(0, 3, sValid, sReady, sData, 8'(mValid), 8'(mReady), 64'(mData), 8'(inFlight));
  end

  // Random-traffic corner instances.
  for (genvar c = 0; c < 2; c++) begin : gCorner
    localparam int D  = (c == 0) ? 1 : 8;
    localparam int NL = (c == 0) ? 1 : 8;
    localparam int CW = $clog2(2*D+1);

    logic            cValid;
    logic            cReady;
    logic [7:0]      cData;
    logic [NL-1:0]   cmValid;
    logic [NL-1:0]   cmReady;
    logic [NL*8-1:0] cmData;
    logic [CW-1:0]   cInFlight;
    logic            doneFlag;

    repeater_fork_pipe #(.WIDTH(8), .DEPTH(D), .NUM_LOADS(NL)) uCorner (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (cValid),
      .s_ready   (cReady),
      .s_data    (cData),
      .m_valid   (cmValid),
      .m_ready   (cmReady),
      .m_data    (cmData),
      .in_flight (cInFlight)
    );

    always @(negedge clk) begin
      observe(c + 1, NL, cValid, cReady, cData, 8'(cmValid), 8'(cmReady), 64'(cmData), 8'(cInFlight));
    end

    // Random valid/ready with a load-ready bias that changes every phase,
    // then a full drain to prove nothing was lost.
    initial begin
      int   thr;
      logic drained;
      doneFlag = 1'b0;
      cValid   = 1'b0;
      cData    = '0;
      cmReady  = '0;
      @(posedge rst_n);
      @(posedge clk);
      #1;
      thr = 50;
      for (int k = 0; k < 1200; k++) begin
        if (k % 150 == 0) thr = $urandom_range(5, 95);
        cValid = ($urandom_range(0, 99) < 70);
        cData  = 8'($urandom);
        for (int i = 0; i < NL; i++) cmReady[i] = ($urandom_range(0, 99) < thr);
        @(posedge clk);
        #1;
      end
      cValid  = 1'b0;
      cmReady = '1;
      drained = 1'b0;
      for (int k = 0; k < 200 && !drained; k++) begin
        @(posedge clk);
        #1;
        drained = (minRx(c + 1, NL) == accCnt[c + 1]);
      end
      checkOutput($sformatf("cornerDrain%0d", c + 1), 64'(minRx(c + 1, NL)), 64'(accCnt[c + 1]));
      checkOutput($sformatf("cornerEmpty%0d", c + 1), 64'(cInFlight), 64'd0);
      doneFlag = 1'b1;
    end
  end

  // One main-instance cycle: drive inputs, sample at the falling edge which
  // transfers the coming rising edge will make, then return just after it.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] r,
                               output logic sFire, output logic [2:0] mFire,
                               output logic [23:0] dOut);
    sValid = v;
    sData  = d;
    mReady = r;
    @(negedge clk);
    sFire = sValid && sReady;
    mFire = mValid & mReady;
    dOut  = mData;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        f;
    logic [2:0]  mf;
    logic [23:0] md;
    int word, firstAcc, firstDel, delivered, bubbles, maxIF, acc, drainedCnt, sent, startAcc, waitCnt;
    logic allIn;

    checks = 0;
    errors = 0;
    sValid = 1'b0;
    sData  = '0;
    mReady = '0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetMValid", 64'(mValid), 64'd0);
    checkOutput("resetInflight", 64'(inFlight), 64'd0);
    checkOutput("resetSReady", 64'(sReady), 64'd1);
    rst_n = 1'b1;

    // Stream 0x01..0x10 with all loads ready.
    word = 1; firstAcc = -1; firstDel = -1; delivered = 0; bubbles = 0; maxIF = 0;
    for (int cyc = 0; cyc < 40 && delivered < 16; cyc++) begin
      applyStimulus(word <= 16, 8'(word), 3'b111, f, mf, md);
      if (f) begin
        if (firstAcc < 0) firstAcc = cyc;
        word++;
      end
      if (mf == 3'b111) begin
        if (firstDel < 0) firstDel = cyc;
        delivered++;
      end else if (firstDel >= 0) begin
        bubbles++;
      end
      if (int'(inFlight) > maxIF) maxIF = int'(inFlight);
    end
    checkOutput("streamFirstAccept", 64'(firstAcc), 64'd0);
    checkOutput("streamLatency", 64'(firstDel - firstAcc), 64'd2);
    checkOutput("streamDelivered", 64'(delivered), 64'd16);
    checkOutput("streamBubbles", 64'(bubbles), 64'd0);
    checkOutput("streamMaxInflight", 64'(maxIF), 64'd2);

    // Fill with every load stalled, then drain.
    acc = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      applyStimulus(1'b1, 8'(8'h40 + acc), 3'b000, f, mf, md);
      if (f) acc++;
    end
    checkOutput("fillAccepts", 64'(acc), 64'd4);
    checkOutput("fillSReady", 64'(sReady), 64'd0);
    checkOutput("fillInflight", 64'(inFlight), 64'd4);
    drainedCnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      applyStimulus(1'b0, 8'h00, 3'b111, f, mf, md);
      if (mf == 3'b111) drainedCnt++;
    end
    checkOutput("drainCycles", 64'(drainedCnt), 64'd4);
    checkOutput("drainSReady", 64'(sReady), 64'd1);
    checkOutput("drainInflight", 64'(inFlight), 64'd0);

    // Skewed loads: load i ready every (i+1)th cycle.
    sent = 0;
    startAcc = accCnt[0];
    allIn = 1'b0;
    for (int cyc = 0; cyc < 300 && !allIn; cyc++) begin
      applyStimulus(sent < 20, 8'(8'h60 + sent),
                    {(cyc % 3 == 0), (cyc % 2 == 0), 1'b1}, f, mf, md);
      if (f) sent++;
      allIn = (minRx(0, 3) == startAcc + 20);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("skewCount%0d", i), 64'(rxCnt[0][i] - startAcc), 64'd20);
    end

    // Accept and retire on the same edge.
    for (int cyc = 0; cyc < 2; cyc++) applyStimulus(1'b1, 8'(8'h31 + cyc), 3'b000, f, mf, md);
    checkOutput("simulPre", 64'(inFlight), 64'd2);
    applyStimulus(1'b1, 8'h33, 3'b111, f, mf, md);
    checkOutput("simulBoth", 64'({f, (mf == 3'b111)}), 64'd3);
    checkOutput("simulInflight", 64'(inFlight), 64'd2);
    for (int cyc = 0; cyc < 4; cyc++) applyStimulus(1'b0, 8'h00, 3'b111, f, mf, md);
    checkOutput("simulDrained", 64'(inFlight), 64'd0);

    // Reset in the middle of traffic.
    for (int cyc = 0; cyc < 3; cyc++) applyStimulus(1'b1, 8'(8'h50 + cyc), 3'b000, f, mf, md);
    checkOutput("rstPre", 64'(inFlight), 64'd3);
    sValid = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("rstMValid", 64'(mValid), 64'd0);
    checkOutput("rstInflight", 64'(inFlight), 64'd0);
    checkOutput("rstSReady", 64'(sReady), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hA5, 3'b111, f, mf, md);
    checkOutput("rstFirstAccept", 64'(f), 64'd1);
    applyStimulus(1'b0, 8'h00, 3'b111, f, mf, md);
    checkOutput("rstLatency1", 64'(mf), 64'd0);
    applyStimulus(1'b0, 8'h00, 3'b111, f, mf, md);
    checkOutput("rstLatency2", 64'(mf), 64'd7);
    checkOutput("rstData", 64'(md), 64'hA5A5A5);

    // Let the corner instances finish.
    waitCnt = 0;
    while (!(gCorner[0].doneFlag && gCorner[1].doneFlag) && waitCnt < 3000) begin
      @(posedge clk);
      waitCnt++;
    end
    checkOutput("cornersFinished", 64'(gCorner[0].doneFlag && gCorner[1].doneFlag), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
